// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and constants for the SRAM burst controller.
//               Holds the controller state enum, the read-tag record, the
//               default SRAM geometry and the saturating-counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

  // Default geometry of the attached SRAM macro.
  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 4;

  // Ceiling for the optional activity counters.
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Tag that travels alongside an issued read until its data is valid.
  typedef struct packed {
    logic valid;
    logic last;
  } rd_tag_t;

  // Increment that sticks at STAT_MAX instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_rd_tag_pipe
// Description : DEPTH-deep shift register carrying {valid,last} read tags so
//               that each tag emerges in the same cycle as the SRAM data of
//               the read it belongs to. Cleared synchronously by rst, which
//               discards every in-flight tag.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_tag_pipe
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  // Two bits per stage; stage 0 occupies the low bits.
  logic [2*DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      // single-stage tag register
      always_ff @(posedge clk) begin
        if (rst) begin
          sr <= '0;
        end else begin
          sr <= tag_in;
        end
      end
    end else begin : g_multi
      // shift tags one stage per clock toward the output end
      always_ff @(posedge clk) begin
        if (rst) begin
          sr <= '0;
        end else begin
          sr <= {sr[2*DEPTH-3:0], tag_in};
        end
      end
    end
  endgenerate

  assign tag_out = sr[2*DEPTH-1 -: 2];

endmodule
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_ctrl
// Description : Burst initiator for a single-port SRAM. Accepts read/write
//               burst commands, streams write beats into the SRAM with
//               address auto-increment (mod 2^AW) and returns read words
//               aligned to the SRAM read latency.
//               Optional macro SRAM_BURST_STATS_EN adds saturating counters
//               of SRAM write cycles and returned read words.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DW     = SRAM_DW,
  parameter int AW     = SRAM_AW,
  parameter int LW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  // command channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  // write-data channel
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  // read-data channel
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          done,
  // SRAM port
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
`ifdef SRAM_BURST_STATS_EN
  ,
  output logic [15:0]   stat_wr_words,
  output logic [15:0]   stat_rd_words
`endif
);

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] addr;       // next write address
  logic [LW-1:0] cnt;        // words remaining after the current one
  logic          last_word;
  logic          accept;
  logic          beat;       // write beat transferred this cycle
  logic          issue;      // read address presented this cycle
  logic          done_wr;
  rd_tag_t       tag_in;
  rd_tag_t       tag_out;

  assign last_word = (cnt == '0);
  assign accept    = req_valid && req_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state decode and per-state handshake outputs
  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    beat      = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_n = req_write ? WR : RD;
        end
      end
      WR: begin
        wr_ready = 1'b1;
        beat     = wr_valid;
        if (wr_valid && last_word) begin
          state_n = IDLE;
        end
      end
      RD: begin
        issue = 1'b1;
        if (last_word) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        // leave as soon as the final tag reaches the output
        if (tag_out.valid && tag_out.last) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // command latch, address/beat counters and registered SRAM drive
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      cnt        <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      done_wr    <= 1'b0;
    end else begin
      sram_we <= 1'b0;
      done_wr <= 1'b0;
      if (accept) begin
        addr <= req_addr;
        cnt  <= req_len;
        // reads present the first address in the very next cycle
        if (!req_write) begin
          sram_addr <= req_addr;
        end
      end else if (beat) begin
        sram_we    <= 1'b1;
        sram_addr  <= addr;
        sram_wdata <= wr_data;
        addr       <= addr + AW'(1);
        cnt        <= cnt - LW'(1);
        done_wr    <= last_word;
      end else if (issue && !last_word) begin
        // reads walk sram_addr directly, one word per cycle
        sram_addr <= sram_addr + AW'(1);
        cnt       <= cnt - LW'(1);
      end
    end
  end

  assign tag_in.valid = issue;
  assign tag_in.last  = issue && last_word;

  sram_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rd_valid = tag_out.valid;
  assign rd_last  = tag_out.valid && tag_out.last;
  assign rd_data  = sram_rdata;
  assign done     = done_wr || rd_last;

`ifdef SRAM_BURST_STATS_EN
  // saturating counts of SRAM write cycles and returned read words
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_words <= '0;
      stat_rd_words <= '0;
    end else begin
      if (sram_we) begin
        stat_wr_words <= sat_inc(stat_wr_words);
      end
      if (rd_valid) begin
        stat_rd_words <= sat_inc(stat_rd_words);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_burst_ctrl
// Description : Self-checking bench for sram_burst_ctrl. Directed table of
//               bursts with hand-derived expectations, reset-abort sequences
//               and randomized bursts checked against an array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_burst_ctrl;

  localparam int RD_LAT = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [3:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        sram_we;
  logic [3:0]  sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
`ifdef SRAM_BURST_STATS_EN
  logic [15:0] stat_wr_words;
  logic [15:0] stat_rd_words;
`endif

  sram_burst_ctrl #(
    .DW(16), .AW(4), .LW(4), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
`ifdef SRAM_BURST_STATS_EN
    , .stat_wr_words(stat_wr_words), .stat_rd_words(stat_rd_words)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: synchronous write, RD_LAT-cycle read
  logic [15:0] mem   [16];
  logic [15:0] rpipe [RD_LAT];
  assign sram_rdata = rpipe[RD_LAT-1];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    rpipe[0] <= mem[sram_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  // reference contents of the array, maintained from the bursts we issue
  logic [15:0] ref_mem [16];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    logic [15:0] data;
    logic [3:0]  addr;
    logic        last;
  } ev_t;

  ev_t we_q [$];
  ev_t rd_q [$];
  int  done_q [$];
  int  base_we = 0;
  int  base_rd = 0;

  // event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (sram_we)  we_q.push_back('{cyc: cyc, data: sram_wdata, addr: sram_addr, last: 1'b0});
    if (rd_valid) rd_q.push_back('{cyc: cyc, data: rd_data, addr: 4'h0, last: rd_last});
    if (done)     done_q.push_back(cyc);
    if (rst) begin
      base_we = we_q.size();
      base_rd = rd_q.size();
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_wr_ready"},   32'(wr_ready),   32'd0);
    chk({tag, "_rd_valid"},   32'(rd_valid),   32'd0);
    chk({tag, "_rd_last"},    32'(rd_last),    32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_sram_we"},    32'(sram_we),    32'd0);
    chk({tag, "_sram_addr"},  32'(sram_addr),  32'd0);
    chk({tag, "_sram_wdata"}, 32'(sram_wdata), 32'd0);
  endtask

  // present a command and wait (bounded) for its acceptance cycle
  task automatic request(input logic w, input logic [3:0] a, input logic [3:0] l, output int acc);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    acc       = -1;
    for (int n = 0; n < 50 && acc < 0; n++) begin
      @(negedge clk);
      if (req_ready) acc = cyc;
      tick();
    end
    req_valid = 1'b0;
    req_addr  = 4'(($urandom));
    req_len   = 4'(($urandom));
    if (acc < 0) chk("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] l,
                          input logic [15:0][15:0] d, input logic [31:0] mask);
    int acc, sent, k, we0, done0;
    int beat_cyc [16];
    logic [3:0]  pa;
    logic [15:0] pd;
    bit have;
    we0 = we_q.size();
    done0 = done_q.size();
    have = 1'b0;
    pa = '0;
    pd = '0;
    request(1'b1, a, l, acc);
    sent = 0;
    k = 0;
    while (sent <= int'(l) && k < 200) begin
      wr_valid = (k >= 32) ? 1'b1 : mask[k];
      wr_data  = d[sent];
      @(negedge clk);
      if (k == 0) chk("wr_req_ready_busy", 32'(req_ready), 32'd0);
      if (sram_we) begin
        have = 1'b1;
        pa = sram_addr;
        pd = sram_wdata;
      end else if (have) begin
        chk("wr_gap_addr_hold",  32'(sram_addr),  32'(pa));
        chk("wr_gap_wdata_hold", 32'(sram_wdata), 32'(pd));
      end
      if (wr_valid && wr_ready) begin
        beat_cyc[sent] = cyc;
        sent++;
      end
      tick();
      k++;
    end
    wr_valid = 1'b0;
    wr_data  = 16'(($urandom));
    repeat (3) tick();
    chk("wr_beats_taken", 32'(sent), 32'(int'(l) + 1));
    chk("wr_we_count", 32'(we_q.size() - we0), 32'(int'(l) + 1));
    for (int i = 0; i <= int'(l) && we0 + i < we_q.size(); i++) begin
      chk("wr_addr",  32'(we_q[we0+i].addr), 32'((int'(a) + i) % 16));
      chk("wr_data",  32'(we_q[we0+i].data), 32'(d[i]));
      chk("wr_we_cyc", 32'(we_q[we0+i].cyc), 32'(beat_cyc[i] + 1));
      ref_mem[(int'(a) + i) % 16] = d[i];
    end
    chk("wr_done_count", 32'(done_q.size() - done0), 32'd1);
    if (done_q.size() > done0)
      chk("wr_done_cyc", 32'(done_q[done0]), 32'(beat_cyc[l] + 1));
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] l, input logic [15:0][15:0] exp);
    int acc, n, rd0, done0, we0;
    rd0 = rd_q.size();
    done0 = done_q.size();
    we0 = we_q.size();
    request(1'b0, a, l, acc);
    n = 0;
    while (done_q.size() == done0 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) chk("rd_done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("rd_req_ready_after_done", 32'(req_ready), 32'd1);
    tick();
    chk("rd_word_count", 32'(rd_q.size() - rd0), 32'(int'(l) + 1));
    for (int i = 0; i <= int'(l) && rd0 + i < rd_q.size(); i++) begin
      chk("rd_cyc",  32'(rd_q[rd0+i].cyc),  32'(acc + 1 + RD_LAT + i));
      chk("rd_data", 32'(rd_q[rd0+i].data), 32'(exp[i]));
      chk("rd_last", 32'(rd_q[rd0+i].last), 32'(i == int'(l)));
    end
    chk("rd_done_count", 32'(done_q.size() - done0), 32'd1);
    if (done_q.size() > done0)
      chk("rd_done_cyc", 32'(done_q[done0]), 32'(acc + 1 + RD_LAT + int'(l)));
    chk("rd_no_sram_we", 32'(we_q.size() - we0), 32'd0);
  endtask

  function automatic logic [15:0][15:0] pack4(input logic [15:0] w0, input logic [15:0] w1,
                                              input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0][15:0] p;
    p = '0;
    p[0] = w0;
    p[1] = w1;
    p[2] = w2;
    p[3] = w3;
    return p;
  endfunction

  function automatic logic [15:0][15:0] ref_words(input logic [3:0] a);
    logic [15:0][15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ref_mem[(int'(a) + i) % 16];
    return p;
  endfunction

  typedef struct packed {
    logic              write;
    logic [3:0]        addr;
    logic [3:0]        len;
    logic [31:0]       mask;
    logic [15:0][15:0] data;   // write beats, or expected read words
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];

  // abort watchdog
  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, rd_snap, we_snap, done_snap;
    logic [15:0][15:0] d;
    logic [15:0] w0;

    tbl[0] = '{write: 1'b1, addr: 4'h0, len: 4'd3, mask: 32'hFFFF_FFFF,
               data: pack4(16'haaaa, 16'h5678, 16'hb4b3, 16'hcccc)};
    tbl[1] = '{write: 1'b0, addr: 4'h0, len: 4'd3, mask: 32'h0,
               data: pack4(16'haaaa, 16'h5678, 16'hb4b3, 16'hcccc)};
    tbl[2] = '{write: 1'b1, addr: 4'h4, len: 4'd3, mask: 32'h0000_0059,
               data: pack4(16'hd001, 16'hd002, 16'hd003, 16'hd004)};
    tbl[3] = '{write: 1'b0, addr: 4'h4, len: 4'd3, mask: 32'h0,
               data: pack4(16'hd001, 16'hd002, 16'hd003, 16'hd004)};
    tbl[4] = '{write: 1'b1, addr: 4'hE, len: 4'd3, mask: 32'hFFFF_FFFF,
               data: pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444)};
    tbl[5] = '{write: 1'b0, addr: 4'h0, len: 4'd1, mask: 32'h0,
               data: pack4(16'h3333, 16'h4444, 16'h0, 16'h0)};
    tbl[6] = '{write: 1'b0, addr: 4'hE, len: 4'd1, mask: 32'h0,
               data: pack4(16'h1111, 16'h2222, 16'h0, 16'h0)};
    tbl[7] = '{write: 1'b0, addr: 4'h2, len: 4'd0, mask: 32'h0,
               data: pack4(16'hb4b3, 16'h0, 16'h0, 16'h0)};

    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    for (int i = 0; i < RD_LAT; i++) rpipe[i] = 16'h0;

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_len = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    tick();

    // directed table
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].write) do_write(tbl[i].addr, tbl[i].len, tbl[i].data, tbl[i].mask);
      else              do_read(tbl[i].addr, tbl[i].len, tbl[i].data);
    end

    // full-array write and read
    for (int i = 0; i < 16; i++) d[i] = 16'(($urandom));
    do_write(4'h3, 4'd15, d, 32'hFFFF_FFFF);
    do_read(4'h3, 4'd15, d);

    // reset during the 3rd word of a 16-word read
    request(1'b0, 4'h0, 4'd15, acc);
    while (cyc < acc + 3 + RD_LAT) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_third_word_valid", 32'(rd_valid), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_rd");
    rd_snap = rd_q.size();
    done_snap = done_q.size();
    we_snap = we_q.size();
    repeat (12) tick();
    chk("rst_rd_no_more_rd_valid", 32'(rd_q.size() - rd_snap), 32'd0);
    chk("rst_rd_no_done", 32'(done_q.size() - done_snap), 32'd0);
    chk("rst_rd_no_we", 32'(we_q.size() - we_snap), 32'd0);

    // reset during the 2nd beat of a write
    w0 = 16'h6a6a;
    we_snap = we_q.size();
    done_snap = done_q.size();
    request(1'b1, 4'h6, 4'd7, acc);
    wr_valid = 1'b1;
    wr_data = w0;
    tick();
    wr_data = 16'h7b7b;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_wr");
    repeat (12) tick();
    chk("rst_wr_single_we", 32'(we_q.size() - we_snap), 32'd1);
    chk("rst_wr_no_done", 32'(done_q.size() - done_snap), 32'd0);
    ref_mem[6] = w0;
    do_read(4'h6, 4'd1, ref_words(4'h6));
    do_read(4'h0, 4'd15, ref_words(4'h0));

    // randomized bursts against the array model
    for (int t = 0; t < 30; t++) begin
      logic [3:0] a;
      logic [3:0] l;
      a = 4'(($urandom));
      l = 4'(($urandom));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) d[i] = 16'(($urandom));
        do_write(a, l, d, $urandom);
      end else begin
        do_read(a, l, ref_words(a));
      end
    end

`ifdef SRAM_BURST_STATS_EN
    chk("stat_wr_words", 32'(stat_wr_words), 32'(we_q.size() - base_we));
    chk("stat_rd_words", 32'(stat_rd_words), 32'(rd_q.size() - base_rd));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
